// File: rtl/btb_pkg.sv
// Shared types and defaults for the BTB update queue.
// Optional feature macro: BTB_UPD_COALESCE_EN (drop repeats of the last accepted record).
package btb_pkg;

  localparam int BTB_XLEN              = 32;
  localparam int BTB_UPD_DEPTH_DEFAULT = 8;

  // One pending BTB write: branch PC, resolved target, return flag.
  typedef struct packed {
    logic [BTB_XLEN-1:0] pc;
    logic [BTB_XLEN-1:0] target;
    logic                is_ret;
  } btb_update_t;

  // Two records describe the same BTB write when PC and target agree.
  function automatic logic same_entry(input btb_update_t a, input btb_update_t b);
    return (a.pc == b.pc) && (a.target == b.target);
  endfunction

endpackage

// File: rtl/btb_update_queue_if.sv
// Commit-side resolution port and BTB-side write port of the BTB update queue.
// Optional feature macro: BTB_UPD_COALESCE_EN (no effect on this interface).
//
// Handshake: res_ready is high when at least two FIFO slots are free. A producer
// may present res_validN only while res_ready is high; a slot is consumed on the
// rising edge where it is valid. There is no stall on the BTB side: update_btb
// is a one-cycle write strobe, never held off.
interface btb_update_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic            res_valid0, res_valid1;
  logic [XLEN-1:0] res_pc0, res_pc1;
  logic            res_taken0, res_taken1;
  logic [XLEN-1:0] res_target0, res_target1;
  logic            res_is_ret0, res_is_ret1;
  logic            res_ready;

  logic            update_btb;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] actual_target_address;
  logic            ex_is_ret;
  logic [PTR_W:0]  count;
  logic            overflow;

  modport slave (
    input  res_valid0, res_valid1, res_pc0, res_pc1, res_taken0, res_taken1,
           res_target0, res_target1, res_is_ret0, res_is_ret1,
    output res_ready, update_btb, ex_pc, actual_target_address, ex_is_ret,
           count, overflow
  );

  modport master (
    output res_valid0, res_valid1, res_pc0, res_pc1, res_taken0, res_taken1,
           res_target0, res_target1, res_is_ret0, res_is_ret1,
    input  res_ready, update_btb, ex_pc, actual_target_address, ex_is_ret,
           count, overflow
  );

endinterface

// File: rtl/btb_upd_fifo.sv
// Two-write / one-read circular FIFO of btb_update_t records.
// Optional feature macro: BTB_UPD_COALESCE_EN (adds the tail_data output).
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter  int DEPTH = BTB_UPD_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  push_cnt,   // 0, 1 or 2 records written this edge
  input  btb_update_t wdata0,     // written at tail
  input  btb_update_t wdata1,     // written at tail+1 when push_cnt == 2
  input  logic        pop,
  output btb_update_t head_data,
`ifdef BTB_UPD_COALESCE_EN
  output btb_update_t tail_data,  // most recently written entry
`endif
  output logic [PTR_W:0] count
);

  btb_update_t    mem_q [DEPTH];
  btb_update_t    mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, tail_p1;
  logic [PTR_W:0]   count_q, count_d;

  // Next-state: write up to two records at tail, advance pointers modulo DEPTH.
  always_comb begin
    mem_d   = mem_q;
    tail_p1 = tail_q + PTR_W'(1);
    if (push_cnt != 2'd0) mem_d[tail_q]  = wdata0;
    if (push_cnt == 2'd2) mem_d[tail_p1] = wdata1;
    tail_d  = tail_q + PTR_W'(push_cnt);
    head_d  = pop ? head_q + PTR_W'(1) : head_q;
    count_d = count_q + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop);
  end

  // Storage is deliberately not reset; only pointers and occupancy are.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
`ifdef BTB_UPD_COALESCE_EN
  assign tail_data = mem_q[tail_q - PTR_W'(1)];
`endif
  assign count     = count_q;

endmodule

// File: rtl/btb_update_queue.sv
// Writer side of the BTB update port: filters taken resolutions from two commit
// slots, buffers them, and emits one registered BTB write per cycle.
// Optional feature macro: BTB_UPD_COALESCE_EN (suppress repeats of the last
// accepted record, including slot 1 repeating slot 0).
module btb_update_queue
  import btb_pkg::*;
#(
  parameter  int XLEN  = BTB_XLEN,
  parameter  int DEPTH = BTB_UPD_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic CLK,
  input  logic reset,
  btb_update_queue_if.slave bus
);

  btb_update_t    rec0, rec1, first_rec, push0, fifo_head;
  btb_update_t    out_q, out_d;
  logic           cand0, cand1, keep0, keep1;
  logic           upd_q, upd_d, ovf_q, ovf_d;
  logic           fifo_empty, fifo_full, pop;
  logic [1:0]     push_cnt;
  logic [PTR_W:0] fifo_count;
`ifdef BTB_UPD_COALESCE_EN
  btb_update_t    fifo_tail, last0;
  logic           last_vld_q, last_vld_d;
`endif

  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (reset),
    .push_cnt  (push_cnt),
    .wdata0    (push0),
    .wdata1    (rec1),
    .pop       (pop),
    .head_data (fifo_head),
`ifdef BTB_UPD_COALESCE_EN
    .tail_data (fifo_tail),
`endif
    .count     (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (PTR_W+1)'(DEPTH));
  assign pop        = ~fifo_empty;

  // Candidate filter: keep valid taken slots, optionally dropping repeats.
  always_comb begin
    rec0  = '{pc: bus.res_pc0, target: bus.res_target0, is_ret: bus.res_is_ret0};
    rec1  = '{pc: bus.res_pc1, target: bus.res_target1, is_ret: bus.res_is_ret1};
    cand0 = bus.res_valid0 & bus.res_taken0;
    cand1 = bus.res_valid1 & bus.res_taken1;
`ifdef BTB_UPD_COALESCE_EN
    // Most recent accepted record lives at the FIFO tail, else in the output register.
    last0 = fifo_empty ? out_q : fifo_tail;
    keep0 = cand0 & ~(last_vld_q & same_entry(rec0, last0));
    keep1 = cand1 & ~(keep0 ? same_entry(rec1, rec0)
                            : (last_vld_q & same_entry(rec1, last0)));
`else
    keep0 = cand0;
    keep1 = cand1;
`endif
    first_rec = keep0 ? rec0 : rec1;
  end

  // Drain, bypass and enqueue: pop head when non-empty, else bypass the first kept record.
  always_comb begin
    upd_d    = 1'b0;
    out_d    = out_q;
    ovf_d    = ovf_q;
    push_cnt = 2'd0;
    push0    = first_rec;
    if (pop) begin
      upd_d = 1'b1;
      out_d = fifo_head;
      if (keep0 && keep1) begin
        // With the same-cycle pop a full FIFO still has room for exactly one.
        if (fifo_full) begin
          push_cnt = 2'd1;
          ovf_d    = 1'b1;
        end else begin
          push_cnt = 2'd2;
        end
      end else if (keep0 || keep1) begin
        push_cnt = 2'd1;
      end
    end else if (keep0 || keep1) begin
      upd_d = 1'b1;
      out_d = first_rec;
      if (keep0 && keep1) begin
        push_cnt = 2'd1;
        push0    = rec1;
      end
    end
`ifdef BTB_UPD_COALESCE_EN
    last_vld_d = last_vld_q | keep0 | keep1;
`endif
  end

  // Output register, write strobe and sticky overflow.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      upd_q      <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef BTB_UPD_COALESCE_EN
      last_vld_q <= 1'b0;
`endif
    end else begin
      upd_q      <= upd_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
`ifdef BTB_UPD_COALESCE_EN
      last_vld_q <= last_vld_d;
`endif
    end
  end

  assign bus.res_ready             = (fifo_count <= (PTR_W+1)'(DEPTH - 2));
  assign bus.update_btb            = upd_q;
  assign bus.ex_pc                 = out_q.pc;
  assign bus.actual_target_address = out_q.target;
  assign bus.ex_is_ret             = out_q.is_ret;
  assign bus.count                 = fifo_count;
  assign bus.overflow              = ovf_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Bench for btb_update_queue: queue-based reference model plus directed and
// randomized scenarios. Honours BTB_UPD_COALESCE_EN when defined.
module tb_btb_update_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int W     = 2*XLEN + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  btb_update_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  btb_update_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];   // records waiting in the FIFO, oldest first
  logic [W-1:0] m_out;      // expected output register {pc,target,is_ret}
  logic         m_upd;
  logic         m_ovf;
  logic [W-1:0] m_last;     // most recently accepted record
  logic         m_last_vld;
  int           m_acc;      // total records accepted since start

  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_reset();
    exp_q.delete();
    m_out = '0; m_upd = 1'b0; m_ovf = 1'b0;
    m_last = '0; m_last_vld = 1'b0;
  endtask

  function automatic bit is_dup(input logic [W-1:0] r, input logic [W-1:0] last, input bit last_vld);
`ifdef BTB_UPD_COALESCE_EN
    return last_vld && (r[W-1:1] == last[W-1:1]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step(input logic v0, t0, input logic [XLEN-1:0] p0, g0, input logic r0,
                            input logic v1, t1, input logic [XLEN-1:0] p1, g1, input logic r1);
    logic [W-1:0] kept[$];
    logic [W-1:0] r;
    if (v0 && t0) begin
      r = {p0, g0, r0};
      if (!is_dup(r, m_last, m_last_vld)) kept.push_back(r);
    end
    if (v1 && t1) begin
      r = {p1, g1, r1};
      if (kept.size() > 0) begin
        if (!is_dup(r, kept[0], 1'b1)) kept.push_back(r);
      end else if (!is_dup(r, m_last, m_last_vld)) begin
        kept.push_back(r);
      end
    end
    if (exp_q.size() > 0) begin
      m_out = exp_q.pop_front();
      m_upd = 1'b1;
    end else if (kept.size() > 0) begin
      m_out = kept.pop_front();
      m_upd = 1'b1;
      m_last = m_out; m_last_vld = 1'b1; m_acc++;
    end else begin
      m_upd = 1'b0;
    end
    foreach (kept[k]) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(kept[k]);
        m_last = kept[k]; m_last_vld = 1'b1; m_acc++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [71:0] exp_vec();
    return {m_upd, m_out, 4'(exp_q.size()), m_ovf, (exp_q.size() <= DEPTH - 2)};
  endfunction

  function automatic logic [71:0] act_vec();
    return {bus.update_btb, bus.ex_pc, bus.actual_target_address, bus.ex_is_ret,
            bus.count, bus.overflow, bus.res_ready};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v0, t0, input logic [XLEN-1:0] p0, g0, input logic r0,
                       input logic v1, t1, input logic [XLEN-1:0] p1, g1, input logic r1,
                       input bit respect_ready);
    @(negedge clk);
    if (respect_ready && !bus.res_ready) begin
      v0 = 1'b0; v1 = 1'b0;
    end
    bus.res_valid0 = v0; bus.res_taken0 = t0; bus.res_pc0 = p0; bus.res_target0 = g0; bus.res_is_ret0 = r0;
    bus.res_valid1 = v1; bus.res_taken1 = t1; bus.res_pc1 = p1; bus.res_target1 = g1; bus.res_is_ret1 = r1;
    @(posedge clk);
    model_step(v0, t0, p0, g0, r0, v1, t1, p1, g1, r1);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rand_dual(input bit respect_ready);
    cycle(1'b1, 1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
          1'b1, 1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), respect_ready);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.update_btb !== 1'b0 || bus.count !== 4'd0 || bus.overflow !== 1'b0 ||
        bus.ex_pc !== 32'h0 || bus.actual_target_address !== 32'h0 || bus.ex_is_ret !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got upd=%b cnt=%0d ovf=%b pc=%h tgt=%h ret=%b, expected all zero",
               bus.update_btb, bus.count, bus.overflow, bus.ex_pc, bus.actual_target_address, bus.ex_is_ret);
    end
    n_tests++;
    if (bus.res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", bus.res_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    cycle(1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    n_tests++;
    if (bus.update_btb !== 1'b1 || bus.ex_pc !== 32'h100 || bus.actual_target_address !== 32'h200 ||
        bus.ex_is_ret !== 1'b0 || bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL single_bypass: got upd=%b pc=%h tgt=%h ret=%b cnt=%0d expected 1/100/200/0/0",
               bus.update_btb, bus.ex_pc, bus.actual_target_address, bus.ex_is_ret, bus.count);
    end
    idle();
    n_tests++;
    if (bus.update_btb !== 1'b0 || bus.ex_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL single_idle: got upd=%b pc=%h expected 0/100", bus.update_btb, bus.ex_pc);
    end
  endtask

  task automatic test_filter();
    int n_upd = 0;
    bit saw_nt = 1'b0;
    cycle(1'b1, 1'b0, 32'h104, 32'h500, 1'b0, 1'b1, 1'b1, 32'h108, 32'h300, 1'b0, 1'b0);
    n_tests++;
    if (bus.update_btb !== 1'b1 || bus.ex_pc !== 32'h108 || bus.actual_target_address !== 32'h300) begin
      n_fail++;
      $display("FAIL filter_first: got upd=%b pc=%h tgt=%h expected 1/108/300",
               bus.update_btb, bus.ex_pc, bus.actual_target_address);
    end
    if (bus.update_btb === 1'b1) n_upd++;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL filter_cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (bus.update_btb === 1'b1) begin
        n_upd++;
        if (bus.ex_pc === 32'h104) saw_nt = 1'b1;
      end
    end
    n_tests++;
    if (n_upd != 1 || saw_nt) begin
      n_fail++;
      $display("FAIL filter_count: got %0d updates (not-taken seen=%0b) expected 1 (0)", n_upd, saw_nt);
    end
  endtask

  task automatic test_burst();
    logic [XLEN-1:0] seen[$];
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 32'(32'h10 + 8*i), 32'(32'h1000 + 8*i), 1'b0,
            1'b1, 1'b1, 32'(32'h14 + 8*i), 32'(32'h1004 + 8*i), 1'b1, 1'b1);
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL burst_push%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (bus.update_btb === 1'b1) seen.push_back(bus.ex_pc);
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL burst_drain%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (bus.update_btb === 1'b1) seen.push_back(bus.ex_pc);
    end
    n_tests++;
    if (seen.size() != 8) begin
      n_fail++;
      $display("FAIL burst_len: got %0d updates expected 8", seen.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (seen[k] !== 32'(32'h10 + 4*k)) begin
          n_fail++;
          $display("FAIL burst_order%0d: got %h expected %h", k, seen[k], 32'(32'h10 + 4*k));
        end
      end
    end
    // Producer honouring res_ready: push pairs until backpressure, then drain.
    for (int i = 0; i < 6; i++) begin
      rand_dual(1'b1);
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_push%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 10; i++) begin
      idle();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_drain%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    int start = m_acc;
    int guard = 0;
    while ((m_acc - start) < 3*DEPTH && guard < 300) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
            1'($urandom_range(0, 1)), 1'b1);
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_cyc%0d: got %h expected %h", guard, act_vec(), exp_vec());
      end
      guard++;
    end
    n_tests++;
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL wrap_budget: accepted %0d expected %0d within 300 cycles", m_acc - start, 3*DEPTH);
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle();
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_drain%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    n_tests++;
    if (bus.overflow !== 1'b0 || bus.count !== 4'd0 || bus.update_btb !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_end: got ovf=%b cnt=%0d upd=%b expected 0/0/0",
               bus.overflow, bus.count, bus.update_btb);
    end
  endtask

  task automatic test_overflow();
    int guard = 0;
    while (exp_q.size() < DEPTH && guard < 40) begin
      rand_dual(1'b0);
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_cyc%0d: got %h expected %h", guard, act_vec(), exp_vec());
      end
      guard++;
    end
    n_tests++;
    if (bus.count !== 4'(DEPTH) || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got cnt=%0d ovf=%b expected %0d/0", bus.count, bus.overflow, DEPTH);
    end
    rand_dual(1'b0);
    n_tests++;
    if (bus.overflow !== 1'b1 || bus.count !== 4'(DEPTH) || bus.res_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_drop: got ovf=%b cnt=%0d rdy=%b expected 1/%0d/0",
               bus.overflow, bus.count, bus.res_ready, DEPTH);
    end
    n_tests++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL overflow_model: got %h expected %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      n_tests++;
      if (bus.overflow !== 1'b1 || act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL overflow_sticky%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    // Asynchronous reset while the queue is still draining.
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.update_btb !== 1'b0 || bus.count !== 4'd0 || bus.overflow !== 1'b0 || bus.res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got upd=%b cnt=%0d ovf=%b rdy=%b expected 0/0/0/1",
               bus.update_btb, bus.count, bus.overflow, bus.res_ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_coalesce();
    int n_upd = 0;
`ifdef BTB_UPD_COALESCE_EN
    int exp_upd = 1;
`else
    int exp_upd = 2;
`endif
    cycle(1'b1, 1'b1, 32'h400, 32'h800, 1'b0, 1'b1, 1'b1, 32'h400, 32'h800, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL coalesce_cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (bus.update_btb === 1'b1) begin
        n_upd++;
        n_tests++;
        if (bus.ex_pc !== 32'h400 || bus.actual_target_address !== 32'h800) begin
          n_fail++;
          $display("FAIL coalesce_data: got pc=%h tgt=%h expected 400/800", bus.ex_pc, bus.actual_target_address);
        end
      end
      idle();
    end
    n_tests++;
    if (n_upd != exp_upd) begin
      n_fail++;
      $display("FAIL coalesce_count: got %0d updates expected %0d", n_upd, exp_upd);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.res_valid0 = 1'b0; bus.res_taken0 = 1'b0; bus.res_pc0 = '0; bus.res_target0 = '0; bus.res_is_ret0 = 1'b0;
    bus.res_valid1 = 1'b0; bus.res_taken1 = 1'b0; bus.res_pc1 = '0; bus.res_target1 = '0; bus.res_is_ret1 = 1'b0;
    m_acc = 0;
    model_reset();
    test_reset();
    test_single();
    test_filter();
    test_burst();
    test_wrap();
    test_overflow();
    test_coalesce();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the whole run is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
